camera_bringup_sequencer: RTL
=============================

CAMERA_BRINGUP_SEQUENCER -- requirements
Module: camera_bringup_sequencer

Interface
REQ-001 SHALL have parameter TIMER_BITS, default 24, width of the shared wait/timeout counter.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1000, fixed delay after each reset release.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum wait for any ready/done input.
REQ-004 SHALL have parameter ALIGN_RETRY, default 3, number of align attempts before the sequencer declares an error.
REQ-005 SHALL have ports: aclk  in  1  the single clock; aresetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: start  in  1  pulse, begin bring-up; stop  in  1  pulse, begin shutdown; clear_error  in  1  pulse, leave ERROR.
REQ-007 SHALL have ports: in_mmcm_locked, in_sensor_ready, in_align_done, in_align_error, in_dphy_init_done  in  1 each  status inputs, already synchronous to aclk.
REQ-008 SHALL have ports: out_mmcm_rst, out_sensor_enable, out_recv_reset, out_align_reset, out_dphy_core_reset, out_dphy_sys_reset  out  1 each  registered controls.
REQ-009 SHALL have ports: busy  out  1; running  out  1; error  out  1; error_code  out  3; state  out  4  current state encoding.

Function
REQ-010 SHALL implement states IDLE, MMCM_UP, SENSOR_ON, RECV_REL, ALIGN, ALIGN_WAIT, DPHY_REL, RUN, SHUTDOWN and ERROR, with a single down-counter timer loaded on every state entry.
REQ-011 IDLE: all resets asserted, sensor off; start -> MMCM_UP.
REQ-012 MMCM_UP: deassert out_mmcm_rst; wait for in_mmcm_locked, then -> SENSOR_ON.
REQ-013 SENSOR_ON: assert out_sensor_enable; wait for in_sensor_ready, then -> RECV_REL.
REQ-014 RECV_REL: deassert out_recv_reset; wait SETTLE_CYCLES, then -> ALIGN.
REQ-015 ALIGN: deassert out_align_reset and increment the attempt counter; -> ALIGN_WAIT.
REQ-016 ALIGN_WAIT outcomes: in_align_done with no error -> DPHY_REL. in_align_error or timeout with attempts < ALIGN_RETRY -> reassert out_align_reset for SETTLE_CYCLES, then -> ALIGN. Otherwise -> ERROR.
REQ-017 DPHY_REL: deassert out_dphy_core_reset and out_dphy_sys_reset together; wait for in_dphy_init_done, then -> RUN.
REQ-018 RUN: running=1; falling in_sensor_ready or in_align_error -> ERROR.
REQ-019 Any wait for a status input exceeding TIMEOUT_CYCLES SHALL -> ERROR with error_code: 1 mmcm, 2 sensor, 3 align, 4 dphy, 5 lost-in-RUN.
REQ-020 stop in any state except IDLE SHALL -> SHUTDOWN; stop SHALL take priority over start, a status transition, or a timeout in the same cycle.
REQ-021 SHUTDOWN SHALL reassert resets in reverse order, one per SETTLE_CYCLES: dphy, align, recv, sensor_enable=0, mmcm_rst=1; then -> IDLE.
REQ-022 ERROR: controls SHALL follow the SHUTDOWN order; error and error_code SHALL be held; clear_error (or stop) SHALL -> IDLE once all resets are reasserted.
REQ-023 start SHALL be ignored outside IDLE; clear_error SHALL be ignored outside ERROR.
REQ-024 Outputs SHALL change one cycle after the state transition (registered); busy SHALL be 1 in every state except IDLE, RUN and ERROR.
REQ-025 The timer SHALL saturate at 0 and never wrap; the 0 value SHALL be treated as expired.

Reset
REQ-026 While aresetn=0, outputs SHALL be: out_mmcm_rst=1, out_sensor_enable=0, all other reset outputs =1, busy=running=error=0, error_code=0, state=IDLE, attempt counter=0, timer=0.
REQ-027 Reset asserted mid-sequence SHALL return the block to IDLE immediately, with no shutdown ordering.

Structure
REQ-028 The state enum and error_code constants SHALL live in a shared package, camera_bringup_pkg.
REQ-029 The timer SHALL be a sub-module named bringup_timer (load, value, expired).
REQ-030 The block SHALL be placed between system_control register bits and the datapath, with a register-selectable bypass at the top level (not in this block).

Verification (SETTLE_CYCLES=4, TIMEOUT_CYCLES=32, ALIGN_RETRY=3)
REQ-031 Nominal: start, then locked/ready/done/init_done each 5 cycles after the request -> RUN, running=1, all resets deasserted, with the release order checked.
REQ-032 Align retry: in_align_error on attempts 1 and 2, done on 3 -> RUN, with out_align_reset pulsed high >=4 cycles twice.
REQ-033 Timeout: in_sensor_ready held 0 -> ERROR after 32 cycles in SENSOR_ON, error_code=2; clear_error -> IDLE.
REQ-034 Stop in RUN: reverse-order reset assertion at 4-cycle spacing -> IDLE, busy=0.
REQ-035 Simultaneous stop and in_dphy_init_done in DPHY_REL -> SHUTDOWN, not RUN.
REQ-036 aresetn low during ALIGN_WAIT -> all outputs at reset values asynchronously; after release, the block stays in IDLE until start.

Source files
------------

// File: rtl/camera_bringup_pkg.sv
// Shared definitions for the camera bring-up sequencer.
//   state_e   : sequencer state encoding, also exported on the 4-bit state port
//   ERR_*     : error_code values reported while in ST_ERROR
//   ctrl_t    : the six registered reset/enable controls, MSB = out_mmcm_rst
package camera_bringup_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_MMCM_UP    = 4'd1,
        ST_SENSOR_ON  = 4'd2,
        ST_RECV_REL   = 4'd3,
        ST_ALIGN      = 4'd4,
        ST_ALIGN_WAIT = 4'd5,
        ST_DPHY_REL   = 4'd6,
        ST_RUN        = 4'd7,
        ST_SHUTDOWN   = 4'd8,
        ST_ERROR      = 4'd9
    } state_e;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_MMCM   = 3'd1;
    localparam logic [2:0] ERR_SENSOR = 3'd2;
    localparam logic [2:0] ERR_ALIGN  = 3'd3;
    localparam logic [2:0] ERR_DPHY   = 3'd4;
    localparam logic [2:0] ERR_LOST   = 3'd5;

    typedef struct packed {
        logic mmcm_rst;
        logic sensor_enable;
        logic recv_reset;
        logic align_reset;
        logic dphy_core_reset;
        logic dphy_sys_reset;
    } ctrl_t;

    // Everything held in reset, sensor powered down.
    localparam ctrl_t CTRL_RESET = '{
        mmcm_rst:        1'b1,
        sensor_enable:   1'b0,
        recv_reset:      1'b1,
        align_reset:     1'b1,
        dphy_core_reset: 1'b1,
        dphy_sys_reset:  1'b1
    };

    // Teardown steps 0..4 reassert dphy, align, recv, sensor, mmcm in turn.
    localparam logic [2:0] SHUT_LAST_STEP = 3'd4;

endpackage

// File: rtl/bringup_timer.sv
// Saturating down-counter shared by every wait in the sequencer.
//   aclk, aresetn : clock, asynchronous active-low reset
//   load          : reload the counter from value (wins over counting)
//   value         : reload value
//   expired       : counter is at zero; it stays there until reloaded
module bringup_timer #(
    parameter int unsigned TIMER_BITS = 24
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load,
    input  logic [TIMER_BITS-1:0] value,
    output logic                  expired
);

    logic [TIMER_BITS-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation order cannot change the result.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/camera_bringup_sequencer.sv
// Power-up / shutdown sequencer for the MIPI camera receive path.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   start/stop           : pulses, begin bring-up / begin shutdown
//   clear_error          : pulse, leave ST_ERROR once teardown has completed
//   in_*                 : status inputs, already synchronous to aclk
//   out_*                : registered reset/enable controls
//   busy/running/error   : registered status; error_code held while in error
//   state                : current state encoding (camera_bringup_pkg::state_e)
module camera_bringup_sequencer
    import camera_bringup_pkg::*;
#(
    parameter int unsigned TIMER_BITS     = 24,
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned ALIGN_RETRY    = 3
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       start,
    input  logic       stop,
    input  logic       clear_error,
    input  logic       in_mmcm_locked,
    input  logic       in_sensor_ready,
    input  logic       in_align_done,
    input  logic       in_align_error,
    input  logic       in_dphy_init_done,
    output logic       out_mmcm_rst,
    output logic       out_sensor_enable,
    output logic       out_recv_reset,
    output logic       out_align_reset,
    output logic       out_dphy_core_reset,
    output logic       out_dphy_sys_reset,
    output logic       busy,
    output logic       running,
    output logic       error,
    output logic [2:0] error_code,
    output logic [3:0] state
);

    localparam int unsigned ATT_W = (ALIGN_RETRY < 2) ? 1 : $clog2(ALIGN_RETRY + 1);
    localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(ALIGN_RETRY);
    // The timer expires on its zero cycle, so load N-1 for an N-cycle dwell.
    localparam logic [TIMER_BITS-1:0] SETTLE_LD  = TIMER_BITS'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_BITS-1:0] TIMEOUT_LD = TIMER_BITS'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        step_q, step_d;        // teardown step in SHUTDOWN/ERROR
    logic              backoff_q, backoff_d;  // ALIGN_WAIT holding align in reset
    logic              leave_q, leave_d;      // clear/stop seen while in ERROR
    logic [ATT_W-1:0]  attempts_q, attempts_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              tmr_load, tmr_expired;
    logic [TIMER_BITS-1:0] tmr_value;
    logic [2:0]        lvl;
    ctrl_t             ctrl_q, ctrl_d;

    bringup_timer #(.TIMER_BITS(TIMER_BITS)) u_timer (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            backoff_q  <= 1'b0;
            leave_q    <= 1'b0;
            attempts_q <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            backoff_q  <= backoff_d;
            leave_q    <= leave_d;
            attempts_q <= attempts_d;
            err_code_q <= err_code_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        backoff_d  = backoff_q;
        leave_d    = leave_q;
        attempts_d = attempts_q;
        err_code_d = err_code_q;
        tmr_load   = 1'b0;
        tmr_value  = TIMEOUT_LD;

        case (state_q)
            ST_IDLE:
                if (start) state_d = ST_MMCM_UP;
            ST_MMCM_UP:
                if (in_mmcm_locked) state_d = ST_SENSOR_ON;
                else if (tmr_expired) begin
                    state_d = ST_ERROR; err_code_d = ERR_MMCM;
                end
            ST_SENSOR_ON:
                if (in_sensor_ready) state_d = ST_RECV_REL;
                else if (tmr_expired) begin
                    state_d = ST_ERROR; err_code_d = ERR_SENSOR;
                end
            ST_RECV_REL:
                if (tmr_expired) state_d = ST_ALIGN;
            ST_ALIGN: begin
                attempts_d = attempts_q + 1'b1;
                state_d    = ST_ALIGN_WAIT;
            end
            ST_ALIGN_WAIT:
                if (backoff_q) begin
                    if (tmr_expired) state_d = ST_ALIGN;
                end else if (in_align_done && !in_align_error) begin
                    state_d = ST_DPHY_REL;
                end else if (in_align_error || tmr_expired) begin
                    if (attempts_q < ATT_MAX) begin
                        backoff_d = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_value = SETTLE_LD;
                    end else begin
                        state_d = ST_ERROR; err_code_d = ERR_ALIGN;
                    end
                end
            ST_DPHY_REL:
                if (in_dphy_init_done) state_d = ST_RUN;
                else if (tmr_expired) begin
                    state_d = ST_ERROR; err_code_d = ERR_DPHY;
                end
            ST_RUN:
                if (!in_sensor_ready || in_align_error) begin
                    state_d = ST_ERROR; err_code_d = ERR_LOST;
                end
            ST_SHUTDOWN:
                if (step_q == SHUT_LAST_STEP) state_d = ST_IDLE;
                else if (tmr_expired) begin
                    step_d = step_q + 3'd1; tmr_load = 1'b1; tmr_value = SETTLE_LD;
                end
            ST_ERROR: begin
                // A clear that arrives mid-teardown is remembered, not dropped.
                if (clear_error || stop) leave_d = 1'b1;
                if (step_q == SHUT_LAST_STEP) begin
                    if (leave_d) state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    step_d = step_q + 3'd1; tmr_load = 1'b1; tmr_value = SETTLE_LD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stop overrides whatever the active state decided this cycle.
        if (stop && !(state_q inside {ST_IDLE, ST_SHUTDOWN, ST_ERROR})) begin
            state_d    = ST_SHUTDOWN;
            err_code_d = err_code_q;
        end

        // Every state entry reloads the timer and clears per-state bookkeeping.
        if (state_d != state_q) begin
            tmr_load  = 1'b1;
            step_d    = '0;
            backoff_d = 1'b0;
            leave_d   = 1'b0;
            case (state_d)
                ST_MMCM_UP, ST_SENSOR_ON, ST_ALIGN_WAIT, ST_DPHY_REL: tmr_value = TIMEOUT_LD;
                ST_RECV_REL, ST_SHUTDOWN, ST_ERROR:                  tmr_value = SETTLE_LD;
                default:                                             tmr_value = '0;
            endcase
            if (state_d == ST_IDLE) begin
                attempts_d = '0;
                err_code_d = ERR_NONE;
            end
        end
    end

    // Bring-up states release controls cumulatively; lvl counts how many are free.
    always_comb begin
        case (state_q)
            ST_MMCM_UP:          lvl = 3'd1;
            ST_SENSOR_ON:        lvl = 3'd2;
            ST_RECV_REL:         lvl = 3'd3;
            ST_ALIGN:            lvl = 3'd4;
            ST_ALIGN_WAIT:       lvl = backoff_q ? 3'd3 : 3'd4;
            ST_DPHY_REL, ST_RUN: lvl = 3'd5;
            default:             lvl = 3'd0;
        endcase

        ctrl_d.mmcm_rst        = (lvl < 3'd1);
        ctrl_d.sensor_enable   = (lvl >= 3'd2);
        ctrl_d.recv_reset      = (lvl < 3'd3);
        ctrl_d.align_reset     = (lvl < 3'd4);
        ctrl_d.dphy_core_reset = (lvl < 3'd5);
        ctrl_d.dphy_sys_reset  = (lvl < 3'd5);

        // Teardown only ever re-asserts, starting from what is currently driven.
        if (state_q == ST_SHUTDOWN || state_q == ST_ERROR) begin
            ctrl_d                 = ctrl_q;
            ctrl_d.dphy_core_reset = 1'b1;
            ctrl_d.dphy_sys_reset  = 1'b1;
            if (step_q >= 3'd1) ctrl_d.align_reset   = 1'b1;
            if (step_q >= 3'd2) ctrl_d.recv_reset    = 1'b1;
            if (step_q >= 3'd3) ctrl_d.sensor_enable = 1'b0;
            if (step_q >= 3'd4) ctrl_d.mmcm_rst      = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_q     <= CTRL_RESET;
            busy       <= 1'b0;
            running    <= 1'b0;
            error      <= 1'b0;
            error_code <= ERR_NONE;
        end else begin
            ctrl_q     <= ctrl_d;
            busy       <= !(state_q inside {ST_IDLE, ST_RUN, ST_ERROR});
            running    <= (state_q == ST_RUN);
            error      <= (state_q == ST_ERROR);
            error_code <= (state_q == ST_ERROR) ? err_code_q : ERR_NONE;
        end
    end

    assign out_mmcm_rst        = ctrl_q.mmcm_rst;
    assign out_sensor_enable   = ctrl_q.sensor_enable;
    assign out_recv_reset      = ctrl_q.recv_reset;
    assign out_align_reset     = ctrl_q.align_reset;
    assign out_dphy_core_reset = ctrl_q.dphy_core_reset;
    assign out_dphy_sys_reset  = ctrl_q.dphy_sys_reset;
    assign state               = state_q;

endmodule
